btn_debounce_multi: RTL and testbench

BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

---
 rtl/btn_debounce_multi.sv | 143 ++++++++++++++
 tb/tb_btn_debounce_multi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// Multi-channel button debouncer: per-channel 2-flop synchronizer, debounce FSM,
// edge pulses, long-press detection and a wrapping press counter.
module btn_debounce_multi_ch #(
   parameter int DB_CYCLES   = 5_000_000,
   parameter int LONG_CYCLES = 100_000_000,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             btn_i,
   input  logic             cnt_clr_i,
   output logic             db_o,
   output logic             rise_o,
   output logic             fall_o,
   output logic             long_o,
   output logic [CNT_W-1:0] cnt_o
);
   localparam int TW = $clog2(DB_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(DB_CYCLES - 1);
   localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);

   localparam logic [1:0] LOW       = 2'd0;
   localparam logic [1:0] WAIT_HIGH = 2'd1;
   localparam logic [1:0] HIGH      = 2'd2;
   localparam logic [1:0] WAIT_LOW  = 2'd3;

   logic [1:0]       sync_q;
   logic [1:0]       state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, rise_q, fall_q, long_q;
   logic             s, db_d, rise_d, fall_d, long_d;

   assign s = sync_q[1];

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         LOW: if (s) begin
            state_d = WAIT_HIGH;
            timer_d = '0;
         end
         WAIT_HIGH: begin
            if (!s)                  state_d = LOW;
            else if (timer_q == T_LAST) state_d = HIGH;
            else                     timer_d = timer_q + TW'(1);
         end
         HIGH: if (!s) begin
            state_d = WAIT_LOW;
            timer_d = '0;
         end
         WAIT_LOW: begin
            if (s)                   state_d = HIGH;
            else if (timer_q == T_LAST) state_d = LOW;
            else                     timer_d = timer_q + TW'(1);
         end
         default: state_d = LOW;
      endcase
   end

   // Only a completed WAIT_x -> stable transition counts as an edge; bounces back are silent.
   assign rise_d = (state_q == WAIT_HIGH) && (state_d == HIGH);
   assign fall_d = (state_q == WAIT_LOW)  && (state_d == LOW);
   assign db_d   = (state_d == HIGH) || (state_d == WAIT_LOW);

   always_comb begin
      hold_d = hold_q;
      if (rise_d)                      hold_d = '0;
      else if (db_q && hold_q != H_MAX) hold_d = hold_q + HW'(1);
   end

   // Saturation keeps hold at H_MAX, so the pulse fires once per press.
   assign long_d = (hold_d == H_MAX) && (hold_q != H_MAX);
   assign cnt_d  = cnt_clr_i ? '0 : cnt_q + CNT_W'(rise_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         state_q <= LOW;
         timer_q <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         state_q <= state_d;
         timer_q <= timer_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         long_q  <= long_d;
      end
   end

   assign db_o   = db_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign long_o = long_q;
   assign cnt_o  = cnt_q;
endmodule

module btn_debounce_multi #(
   parameter int N_CH        = 4,
   parameter int DB_CYCLES   = 5_000_000,
   parameter int LONG_CYCLES = 100_000_000,
   parameter int CNT_W       = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [N_CH-1:0]       btn,
   input  logic                  cnt_clr,
   output logic [N_CH-1:0]       db,
   output logic [N_CH-1:0]       rise,
   output logic [N_CH-1:0]       fall,
   output logic [N_CH-1:0]       long_press,
   output logic [N_CH*CNT_W-1:0] cnt
);
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_debounce_multi_ch #(
         .DB_CYCLES  (DB_CYCLES),
         .LONG_CYCLES(LONG_CYCLES),
         .CNT_W      (CNT_W)
      ) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .btn_i    (btn[i]),
         .cnt_clr_i(cnt_clr),
         .db_o     (db[i]),
         .rise_o   (rise[i]),
         .fall_o   (fall[i]),
         .long_o   (long_press[i]),
         .cnt_o    (cnt[i*CNT_W +: CNT_W])
      );
   end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: press-length table plus hand-written
// latency, long-press, counter-wrap/clear and reset-abort sequences.
module tb_btn_debounce_multi;
   localparam int N_CH = 4, DB = 8, LONG = 40, CW = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N_CH-1:0]   btn;
   logic              cnt_clr;
   logic [N_CH-1:0]   db, rise, fall, long_press;
   logic [N_CH*CW-1:0] cnt;

   int checks = 0, failures = 0;
   int rise_n[N_CH], fall_n[N_CH], long_n[N_CH];

   btn_debounce_multi #(.N_CH(N_CH), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .btn(btn), .cnt_clr(cnt_clr),
      .db(db), .rise(rise), .fall(fall), .long_press(long_press), .cnt(cnt)
   );

   always #5 clk = ~clk;

   // Running totals of pulse-high cycles; tests work on differences.
   initial for (int i = 0; i < N_CH; i++) begin rise_n[i] = 0; fall_n[i] = 0; long_n[i] = 0; end
   always @(negedge clk)
      for (int i = 0; i < N_CH; i++) begin
         rise_n[i] += int'(rise[i]);
         fall_n[i] += int'(fall[i]);
         long_n[i] += int'(long_press[i]);
      end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int cnt_of(input int ch);
      return int'(cnt[ch*CW +: CW]);
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      int ch; int len; int e_rise; int e_fall; int e_long; int e_inc;
   } vec_t;
   vec_t tbl[8];

   initial begin
      int r0[N_CH], f0[N_CH], l0[N_CH], c0;
      tbl[0] = '{0, 1,  0, 0, 0, 0};
      tbl[1] = '{1, 3,  0, 0, 0, 0};
      tbl[2] = '{2, 8,  0, 0, 0, 0};
      tbl[3] = '{3, 9,  1, 1, 0, 1};
      tbl[4] = '{0, 20, 1, 1, 0, 1};
      tbl[5] = '{1, 39, 1, 1, 0, 1};
      tbl[6] = '{2, 40, 1, 1, 1, 1};
      tbl[7] = '{3, 60, 1, 1, 1, 1};

      btn = '0; cnt_clr = 1'b0; reset_n = 1'b0;
      cyc(3);
      chk("rst_db", int'(db), 0);
      chk("rst_pulses", int'({rise, fall, long_press}), 0);
      chk("rst_cnt", int'(cnt), 0);
      reset_n = 1'b1;

      // ch0 step: db after edge 11, one rise, count next cycle, fall 11 edges after release
      cyc(1); btn[0] = 1'b1;
      cyc(10);
      chk("ch0_db_edge10", int'(db[0]), 0);
      cyc(1);
      chk("ch0_db_edge11", int'(db[0]), 1);
      chk("ch0_rise_edge11", int'(rise[0]), 1);
      chk("ch0_cnt_edge11", cnt_of(0), 0);
      cyc(1);
      chk("ch0_rise_edge12", int'(rise[0]), 0);
      chk("ch0_cnt_edge12", cnt_of(0), 1);
      cyc(5); btn[0] = 1'b0;
      cyc(10);
      chk("ch0_db_rel10", int'(db[0]), 1);
      cyc(1);
      chk("ch0_db_rel11", int'(db[0]), 0);
      chk("ch0_fall_rel11", int'(fall[0]), 1);
      cyc(5);

      // ch1 bouncing with 3-cycle highs never qualifies
      c0 = rise_n[1];
      for (int k = 0; k < 10; k++) begin
         btn[1] = 1'b1; cyc(3); btn[1] = 1'b0; cyc(3);
         if (db[1]) chk("ch1_bounce_db", 1, 0);
      end
      cyc(12);
      chk("ch1_bounce_rise", rise_n[1] - c0, 0);
      chk("ch1_bounce_cnt", cnt_of(1), 0);

      // ch2 held 100 cycles: one long_press exactly 40 cycles after db rises
      l0[2] = long_n[2]; f0[2] = fall_n[2];
      btn[2] = 1'b1;
      cyc(11);
      chk("ch2_db_rise", int'(db[2]), 1);
      cyc(39);
      chk("ch2_long_early", long_n[2] - l0[2], 0);
      cyc(1);
      chk("ch2_long_at40", int'(long_press[2]), 1);
      cyc(49);
      chk("ch2_long_once", long_n[2] - l0[2], 1);
      btn[2] = 1'b0;
      cyc(10);
      chk("ch2_fall_early", fall_n[2] - f0[2], 0);
      cyc(1);
      chk("ch2_fall_at11", int'(fall[2]), 1);
      chk("ch2_db_low", int'(db[2]), 0);
      cyc(5);

      // reset mid-debounce with btn[0] held: outputs zero, then a fresh press
      btn[0] = 1'b1;
      cyc(5);
      reset_n = 1'b0;
      #1;
      chk("rst2_db", int'(db), 0);
      chk("rst2_pulses", int'({rise, fall, long_press}), 0);
      chk("rst2_cnt", int'(cnt), 0);
      cyc(3);
      chk("rst2_cnt_hold", int'(cnt), 0);
      reset_n = 1'b1;
      cyc(10);
      chk("rst2_db_edge10", int'(db[0]), 0);
      cyc(1);
      chk("rst2_db_edge11", int'(db[0]), 1);
      chk("rst2_rise", int'(rise[0]), 1);
      cyc(1);
      chk("rst2_cnt", cnt_of(0), 1);
      btn[0] = 1'b0;
      cyc(20);

      // press-length table: boundary at 9 samples for a press, 40 for a long press
      foreach (tbl[t]) begin
         for (int i = 0; i < N_CH; i++) begin r0[i] = rise_n[i]; f0[i] = fall_n[i]; l0[i] = long_n[i]; end
         c0 = cnt_of(tbl[t].ch);
         btn[tbl[t].ch] = 1'b1;
         cyc(tbl[t].len);
         btn[tbl[t].ch] = 1'b0;
         cyc(30);
         chk($sformatf("tbl%0d_rise", t), rise_n[tbl[t].ch] - r0[tbl[t].ch], tbl[t].e_rise);
         chk($sformatf("tbl%0d_fall", t), fall_n[tbl[t].ch] - f0[tbl[t].ch], tbl[t].e_fall);
         chk($sformatf("tbl%0d_long", t), long_n[tbl[t].ch] - l0[tbl[t].ch], tbl[t].e_long);
         chk($sformatf("tbl%0d_cnt", t), (cnt_of(tbl[t].ch) - c0) & 15, tbl[t].e_inc);
         for (int i = 0; i < N_CH; i++)
            if (i != tbl[t].ch)
               chk($sformatf("tbl%0d_other%0d", t, i),
                   (rise_n[i] - r0[i]) + (fall_n[i] - f0[i]) + (long_n[i] - l0[i]), 0);
      end

      // ch3: clear, 17 presses wrap to 1, then clear coinciding with a rise wins
      cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
      chk("clr_all", int'(cnt), 0);
      for (int k = 0; k < 17; k++) begin
         btn[3] = 1'b1; cyc(12); btn[3] = 1'b0; cyc(14);
      end
      chk("ch3_wrap", cnt_of(3), 1);
      btn[3] = 1'b1;
      cyc(11);
      chk("ch3_rise_for_clr", int'(rise[3]), 1);
      cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
      chk("ch3_clr_prio", cnt_of(3), 0);
      chk("ch3_db_kept", int'(db[3]), 1);
      cyc(1);
      chk("ch3_clr_stays", cnt_of(3), 0);
      btn[3] = 1'b0;
      cyc(15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
